// File: rtl/req_pending_pkg.sv
// Shared types and constants for the request-collection stage in front of the
// 3-input priority encoder.
package req_pending_pkg;

    localparam int NUM_SRC = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    localparam logic [1:0] CODE_S1   = 2'b00;
    localparam logic [1:0] CODE_S2   = 2'b01;
    localparam logic [1:0] CODE_S3   = 2'b10;
    localparam logic [1:0] CODE_NONE = 2'b11;

endpackage

// File: rtl/req_pending_ctrl_sat_cnt.sv
// Saturating up-counter used to tally requests lost to an already-pending source.
module sat_cnt #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CW{1'b1}})) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/req_pending_ctrl.sv
// Collects request pulses into sticky pending bits and offers a frozen snapshot
// to the priority encoder through a valid/ready handshake.
//
// state    | meaning
// ST_IDLE  | no offer; snapshot pend into sel when anything is pending
// ST_OFFER | sel frozen, svc_valid high until the consumer fires
module req_pending_ctrl
    import req_pending_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    req,
    output logic          sel1,
    output logic          sel2,
    output logic          sel3,
    input  logic [1:0]    grant_code,
    output logic          svc_valid,
    input  logic          svc_ready,
    output logic [CW-1:0] drop_cnt1,
    output logic [CW-1:0] drop_cnt2,
    output logic [CW-1:0] drop_cnt3,
    output logic          err
);

    state_t               state;
    logic [NUM_SRC-1:0]   pend;
    logic [NUM_SRC-1:0]   sel;
    logic [NUM_SRC-1:0]   clr;
    logic [NUM_SRC-1:0]   drop_inc;
    logic [CW-1:0]        cnt [NUM_SRC];
    logic                 fire;

    assign svc_valid = (state == ST_OFFER);
    assign fire      = svc_valid & svc_ready;

    always_comb begin
        clr = '0;
        if (fire) begin
            case (grant_code)
                CODE_S1: clr = 3'b001;
                CODE_S2: clr = 3'b010;
                CODE_S3: clr = 3'b100;
                default: clr = 3'b000;
            endcase
        end
    end

    // A request on a bit being cleared this cycle re-arms it rather than dropping.
    assign drop_inc = req & pend & ~clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~clr) | req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            sel   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pend != '0) begin
                        sel   <= pend;
                        state <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (fire) begin
                        sel   <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    sel   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (fire && (grant_code == CODE_NONE)) begin
            err <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_drop
        sat_cnt #(.CW(CW)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (drop_inc[i]),
            .count (cnt[i])
        );
    end

    assign sel1      = sel[0];
    assign sel2      = sel[1];
    assign sel3      = sel[2];
    assign drop_cnt1 = cnt[0];
    assign drop_cnt2 = cnt[1];
    assign drop_cnt3 = cnt[2];

endmodule

// File: tb/tb_req_pending_ctrl.sv
// Directed testbench for req_pending_ctrl with a behavioural priority encoder
// closing the loop from sel outputs back to grant_code.
module tb_req_pending_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    req = 3'b000;
    logic          sel1, sel2, sel3;
    logic [1:0]    grant_code;
    logic          svc_valid;
    logic          svc_ready = 1'b0;
    logic [CW-1:0] drop_cnt1, drop_cnt2, drop_cnt3;
    logic          err;
    logic          force_none = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    req_pending_ctrl #(.CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .sel1       (sel1),
        .sel2       (sel2),
        .sel3       (sel3),
        .grant_code (grant_code),
        .svc_valid  (svc_valid),
        .svc_ready  (svc_ready),
        .drop_cnt1  (drop_cnt1),
        .drop_cnt2  (drop_cnt2),
        .drop_cnt3  (drop_cnt3),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Encoder model: src1 highest priority; force_none injects the illegal code.
    always_comb begin
        if (force_none)  grant_code = 2'b11;
        else if (sel1)   grant_code = 2'b00;
        else if (sel2)   grant_code = 2'b01;
        else if (sel3)   grant_code = 2'b10;
        else             grant_code = 2'b11;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 3'b000;
        svc_ready = 1'b0;
        force_none = 1'b0;
        #2;
        rst = 1'b0;
        tick();
    endtask

    // Pulse req for one sampling edge, then wait one more edge to reach OFFER.
    task automatic load_offer(input logic [2:0] r);
        req = r;
        tick();
        req = 3'b000;
        tick();
    endtask

    task automatic drain();
        svc_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!svc_valid && ({sel3, sel2, sel1} == 3'b000)) begin
                tick();
                if (!svc_valid) break;
            end else begin
                tick();
            end
        end
        svc_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({svc_valid, sel3, sel2, sel1, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected 00000", {svc_valid, sel3, sel2, sel1, err});
        end
        load_offer(3'b101);
        n_tests++;
        if ({svc_valid, sel3, sel2, sel1} !== 4'b1101) begin
            n_fail++;
            $display("FAIL reset_preoffer: got %b expected 1101", {svc_valid, sel3, sel2, sel1});
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({svc_valid, sel3, sel2, sel1, err, drop_cnt1, drop_cnt2, drop_cnt3} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: valid=%b sel=%b err=%b cnt=%0d/%0d/%0d expected all 0",
                     svc_valid, {sel3, sel2, sel1}, err, drop_cnt1, drop_cnt2, drop_cnt3);
        end
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (svc_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_quiet cycle %0d: valid=%b expected 0", i, svc_valid);
            end
        end
    endtask

    task automatic test_single();
        req = 3'b010;
        tick();
        req = 3'b000;
        n_tests++;
        if (svc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency: valid=%b expected 0 one edge after sampling", svc_valid);
        end
        tick();
        n_tests++;
        if ({svc_valid, sel3, sel2, sel1} !== 4'b1010 || grant_code !== 2'b01) begin
            n_fail++;
            $display("FAIL single_offer: valid/sel=%b code=%b expected 1010 code 01",
                     {svc_valid, sel3, sel2, sel1}, grant_code);
        end
        svc_ready = 1'b1;
        tick();
        svc_ready = 1'b0;
        n_tests++;
        if ({svc_valid, sel3, sel2, sel1} !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_fire: valid/sel=%b expected 0000", {svc_valid, sel3, sel2, sel1});
        end
        tick();
    endtask

    task automatic test_priority_drain();
        logic [1:0] exp_code [3];
        logic [2:0] exp_sel [3];
        exp_code[0] = 2'b00; exp_code[1] = 2'b01; exp_code[2] = 2'b10;
        exp_sel[0]  = 3'b111; exp_sel[1] = 3'b110; exp_sel[2] = 3'b100;
        req = 3'b111;
        tick();
        req = 3'b000;
        svc_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (svc_valid !== 1'b1 || grant_code !== exp_code[k] || {sel3, sel2, sel1} !== exp_sel[k]) begin
                n_fail++;
                $display("FAIL drain_grant %0d: valid=%b code=%b sel=%b expected 1 %b %b",
                         k, svc_valid, grant_code, {sel3, sel2, sel1}, exp_code[k], exp_sel[k]);
            end
            tick();
            n_tests++;
            if (svc_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_idle %0d: valid=%b expected 0", k, svc_valid);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (svc_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_empty %0d: valid=%b expected 0", i, svc_valid);
            end
        end
        svc_ready = 1'b0;
    endtask

    task automatic test_frozen();
        load_offer(3'b100);
        req = 3'b001;
        tick();
        req = 3'b000;
        n_tests++;
        if ({svc_valid, sel3, sel2, sel1} !== 4'b1100) begin
            n_fail++;
            $display("FAIL frozen_hold: valid/sel=%b expected 1100", {svc_valid, sel3, sel2, sel1});
        end
        svc_ready = 1'b1;
        tick();
        svc_ready = 1'b0;
        tick();
        n_tests++;
        if ({svc_valid, sel3, sel2, sel1} !== 4'b1001) begin
            n_fail++;
            $display("FAIL frozen_next: valid/sel=%b expected 1001", {svc_valid, sel3, sel2, sel1});
        end
        drain();
    endtask

    task automatic test_drops();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            req = 3'b001;
            tick();
            req = 3'b000;
            tick();
            if (i == 4) begin
                n_tests++;
                if (drop_cnt1 !== 4'd4) begin
                    n_fail++;
                    $display("FAIL drop_partial: drop_cnt1=%0d expected 4", drop_cnt1);
                end
            end
        end
        n_tests++;
        if (drop_cnt1 !== 4'd15 || drop_cnt2 !== 4'd0 || drop_cnt3 !== 4'd0) begin
            n_fail++;
            $display("FAIL drop_sat: cnt=%0d/%0d/%0d expected 15/0/0", drop_cnt1, drop_cnt2, drop_cnt3);
        end
        drain();
    endtask

    task automatic test_set_wins();
        do_reset();
        load_offer(3'b001);
        svc_ready = 1'b1;
        req = 3'b001;
        tick();
        svc_ready = 1'b0;
        req = 3'b000;
        n_tests++;
        if (svc_valid !== 1'b0 || drop_cnt1 !== 4'd0) begin
            n_fail++;
            $display("FAIL setwins_fire: valid=%b drop_cnt1=%0d expected 0 0", svc_valid, drop_cnt1);
        end
        tick();
        n_tests++;
        if ({svc_valid, sel3, sel2, sel1} !== 4'b1001) begin
            n_fail++;
            $display("FAIL setwins_reoffer: valid/sel=%b expected 1001", {svc_valid, sel3, sel2, sel1});
        end
        drain();
    endtask

    task automatic test_protocol_err();
        do_reset();
        load_offer(3'b001);
        force_none = 1'b1;
        svc_ready = 1'b1;
        tick();
        force_none = 1'b0;
        svc_ready = 1'b0;
        n_tests++;
        if (err !== 1'b1 || svc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_set: err=%b valid=%b expected 1 0", err, svc_valid);
        end
        tick();
        n_tests++;
        if ({svc_valid, sel3, sel2, sel1} !== 4'b1001) begin
            n_fail++;
            $display("FAIL err_reoffer: valid/sel=%b expected 1001", {svc_valid, sel3, sel2, sel1});
        end
        drain();
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: err=%b expected 1", err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority_drain();
        test_frozen();
        test_drops();
        test_set_wins();
        test_protocol_err();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
